// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: frequency-word sweep sequencer feeding the DDS phase accumulator.
// Ramps a latched start..stop range in single, sawtooth or triangle fashion,
// holding each word for a programmable dwell and strobing upd on every change.
module dds_sweep_ctrl #(
    parameter int unsigned FW_W    = 8,
    parameter int unsigned DWELL_W = 16,
    parameter int unsigned FW_RST  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop_req,
    input  logic [1:0]         mode,
    input  logic [FW_W-1:0]    f_start,
    input  logic [FW_W-1:0]    f_stop,
    input  logic [FW_W-1:0]    f_step,
    input  logic [DWELL_W-1:0] dwell,
    output logic [FW_W-1:0]    fword,
    output logic               upd,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_UP   = 2'd1;
    localparam logic [1:0] S_DN   = 2'd2;

    localparam logic [1:0] M_REPEAT   = 2'b01;
    localparam logic [1:0] M_TRIANGLE = 2'b10;

    logic [1:0]         state_q,   state_d;
    logic [FW_W-1:0]    fword_q,   fword_d;
    logic               upd_q,     upd_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;
    logic               cfg_err_q, cfg_err_d;
    logic [DWELL_W-1:0] cnt_q,     cnt_d;
    logic [1:0]         mode_q,    mode_d;
    logic [FW_W-1:0]    fs_q,      fs_d;
    logic [FW_W-1:0]    fe_q,      fe_d;
    logic [FW_W-1:0]    st_q,      st_d;
    logic [DWELL_W-1:0] dw_q,      dw_d;

    logic [FW_W:0]      sum_w;
    logic [FW_W:0]      diff_w;
    logic               up_ok;
    logic               dn_ok;
    logic [FW_W-1:0]    up_clip;
    logic [FW_W-1:0]    dn_clip;
    logic [DWELL_W-1:0] dwell_eff;
    logic               step_now;

    // Candidate next words with carry/borrow kept in the extra MSB.
    always_comb begin
        sum_w     = {1'b0, fword_q} + {1'b0, st_q};
        diff_w    = {1'b0, fword_q} - {1'b0, st_q};
        up_ok     = !sum_w[FW_W] && (sum_w[FW_W-1:0] <= fe_q);
        dn_ok     = !diff_w[FW_W] && (diff_w[FW_W-1:0] >= fs_q);
        up_clip   = (sum_w[FW_W] || (sum_w[FW_W-1:0] > fe_q)) ? fe_q : sum_w[FW_W-1:0];
        dn_clip   = (diff_w[FW_W] || (diff_w[FW_W-1:0] < fs_q)) ? fs_q : diff_w[FW_W-1:0];
        dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
        step_now  = (cnt_q == DWELL_W'(1));
    end

    // Next-state and output decode; stop_req overrides everything else.
    always_comb begin
        state_d   = state_q;
        fword_d   = fword_q;
        upd_d     = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cfg_err_d = 1'b0;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        fs_d      = fs_q;
        fe_d      = fe_q;
        st_d      = st_q;
        dw_d      = dw_q;

        if (stop_req) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if ((f_step == '0) || (f_start > f_stop)) begin
                            cfg_err_d = 1'b1;
                        end else begin
                            mode_d  = mode;
                            fs_d    = f_start;
                            fe_d    = f_stop;
                            st_d    = f_step;
                            dw_d    = dwell_eff;
                            cnt_d   = dwell_eff;
                            fword_d = f_start;
                            upd_d   = 1'b1;
                            busy_d  = 1'b1;
                            state_d = S_UP;
                        end
                    end
                end
                S_UP: begin
                    if (step_now) begin
                        cnt_d = dw_q;
                        if (up_ok) begin
                            fword_d = sum_w[FW_W-1:0];
                            upd_d   = (sum_w[FW_W-1:0] != fword_q);
                        end else if (mode_q == M_REPEAT) begin
                            fword_d = fs_q;
                            upd_d   = (fs_q != fword_q);
                        end else if (mode_q == M_TRIANGLE) begin
                            state_d = S_DN;
                            fword_d = dn_clip;
                            upd_d   = (dn_clip != fword_q);
                        end else begin
                            cnt_d   = '0;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = S_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q - DWELL_W'(1);
                    end
                end
                S_DN: begin
                    if (step_now) begin
                        cnt_d = dw_q;
                        if (dn_ok) begin
                            fword_d = diff_w[FW_W-1:0];
                            upd_d   = (diff_w[FW_W-1:0] != fword_q);
                        end else begin
                            state_d = S_UP;
                            fword_d = up_clip;
                            upd_d   = (up_clip != fword_q);
                        end
                    end else begin
                        cnt_d = cnt_q - DWELL_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            fword_q   <= FW_W'(FW_RST);
            upd_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            cnt_q     <= '0;
            mode_q    <= '0;
            fs_q      <= '0;
            fe_q      <= '0;
            st_q      <= '0;
            dw_q      <= '0;
        end else begin
            state_q   <= state_d;
            fword_q   <= fword_d;
            upd_q     <= upd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            fs_q      <= fs_d;
            fe_q      <= fe_d;
            st_q      <= st_d;
            dw_q      <= dw_d;
        end
    end

    assign fword   = fword_q;
    assign upd     = upd_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: the driver derives the expected strobe
// events of each sweep from the sweep rules and queues them; the monitor pops
// and compares on every upd/done/cfg_err the DUT presents.
module tb_dds_sweep_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop_req = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [7:0]  f_start = 8'd0;
    logic [7:0]  f_stop = 8'd0;
    logic [7:0]  f_step = 8'd0;
    logic [15:0] dwell = 16'd0;
    logic [7:0]  fword;
    logic        upd, busy, done, cfg_err;

    dds_sweep_ctrl #(.FW_W(8), .DWELL_W(16), .FW_RST(1)) dut (
        .clk(clk), .reset(reset), .start(start), .stop_req(stop_req),
        .mode(mode), .f_start(f_start), .f_stop(f_stop), .f_step(f_step),
        .dwell(dwell), .fword(fword), .upd(upd), .busy(busy), .done(done),
        .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int       edge_n;
        logic [2:0] kind;   // {upd, done, cfg_err}
        int       fw;
        logic     bsy;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    int  checks = 0;
    int  errors = 0;
    int  exp_fw = 1;

    // Monitor: every strobe the DUT shows must match the head of the queue.
    always @(negedge clk) begin
        if (!reset && (upd || done || cfg_err)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event cyc=%0d upd=%b done=%b cfg_err=%b fword=%0d",
                         cyc, upd, done, cfg_err, fword);
            end else begin
                mon_e = exp_q.pop_front();
                if ({upd, done, cfg_err} !== mon_e.kind || fword !== 8'(mon_e.fw) ||
                    busy !== mon_e.bsy || cyc != mon_e.edge_n) begin
                    errors++;
                    $display("FAIL event got cyc=%0d kind=%b fword=%0d busy=%b required cyc=%0d kind=%b fword=%0d busy=%b",
                             cyc, {upd, done, cfg_err}, fword, busy,
                             mon_e.edge_n, mon_e.kind, mon_e.fw, mon_e.bsy);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    task automatic push(input int e, input logic [2:0] k, input int fw, input logic b);
        ev_t x;
        x.edge_n = e;
        x.kind   = k;
        x.fw     = fw;
        x.bsy    = b;
        exp_q.push_back(x);
    endtask

    // One sweep: start in cycle c, optionally stop (or reset) in cycle c+stop_at.
    task automatic run(input int m, input int fs, input int fe, input int st,
                       input int dw, input int stop_at, input bit use_rst);
        int  c, d, limit, e, w, prev, last;
        bit  up, fin, valid;
        @(posedge clk); #1;
        mode = 2'(m); f_start = 8'(fs); f_stop = 8'(fe); f_step = 8'(st);
        dwell = 16'(dw); start = 1'b1;
        c = cyc;
        valid = (st != 0) && (fs <= fe);
        last = c + 1;
        fin = 1'b0;
        if (!valid) begin
            push(c + 1, 3'b001, exp_fw, 1'b0);
        end else begin
            d = (dw == 0) ? 1 : dw;
            if (stop_at == 0) limit = 32'h7fff_ffff;
            else limit = use_rst ? c + stop_at - 1 : c + stop_at;
            e = c + 1; w = fs; prev = fs; up = 1'b1;
            if (e <= limit) begin
                push(e, 3'b100, w, 1'b1); exp_fw = w; last = e;
                forever begin
                    e += d;
                    if (e > limit) break;
                    if (up) begin
                        if (w + st <= fe) w = w + st;
                        else if (m == 1) w = fs;
                        else if (m == 2) begin up = 1'b0; w = (w - st > fs) ? w - st : fs; end
                        else fin = 1'b1;
                    end else begin
                        if (w - st >= fs) w = w - st;
                        else begin up = 1'b1; w = (w + st < fe) ? w + st : fe; end
                    end
                    if (fin) begin push(e, 3'b010, w, 1'b0); last = e; break; end
                    if (w != prev) begin push(e, 3'b100, w, 1'b1); exp_fw = w; last = e; end
                    prev = w;
                end
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
        f_start = 8'($urandom); f_stop = 8'($urandom); f_step = 8'($urandom);
        dwell = 16'($urandom_range(0, 3)); mode = 2'($urandom);
        if (valid && stop_at > 0) begin
            while (cyc < c + stop_at) begin @(posedge clk); #1; end
            if (use_rst) begin
                reset = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    check("rst_fword", int'(fword), 1);
                    check("rst_busy", int'(busy), 0);
                    check("rst_strobes", int'({upd, done, cfg_err}), 0);
                end
                @(posedge clk); #1;
                reset = 1'b0;
                exp_fw = 1;
            end else begin
                if (!fin) check("busy_before_stop", int'(busy), 1);
                stop_req = 1'b1;
                @(posedge clk); #1;
                stop_req = 1'b0;
                check("busy_after_stop", int'(busy), 0);
                check("fword_held_stop", int'(fword), exp_fw);
            end
        end
        while (cyc < last + 3) begin @(posedge clk); #1; end
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
        check("idle_busy", int'(busy), 0);
        check("idle_fword", int'(fword), exp_fw);
    endtask

    // start and stop_req in the same cycle: no sweep, no strobe.
    task automatic collide();
        @(posedge clk); #1;
        mode = 2'b01; f_start = 8'd20; f_stop = 8'd60; f_step = 8'd5; dwell = 16'd1;
        start = 1'b1; stop_req = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; stop_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("collide_busy", int'(busy), 0);
        check("collide_fword", int'(fword), exp_fw);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int m, fs, fe, st, dw, sa;
        bit rs;
        repeat (3) @(posedge clk);
        #1;
        check("reset_fword", int'(fword), 1);
        check("reset_outs", int'({upd, busy, done, cfg_err}), 0);
        reset = 1'b0;

        run(0, 10, 40, 10, 3, 0, 0);     // 10,20,30,40 then done
        run(0, 10, 35, 10, 1, 0, 0);     // non-multiple stop
        run(0, 200, 255, 100, 2, 0, 0);  // carry out ends the sweep
        run(2, 10, 30, 10, 1, 17, 0);    // triangle, aborted
        run(1, 50, 50, 5, 2, 15, 0);     // equal bounds, no further upd
        run(2, 60, 60, 7, 1, 9, 0);
        run(0, 5, 100, 0, 1, 0, 0);      // step zero
        run(0, 40, 10, 5, 1, 0, 0);      // inverted bounds
        collide();
        run(0, 10, 40, 10, 0, 0, 0);     // dwell 0 acts as 1
        run(3, 0, 30, 15, 2, 0, 0);      // mode 11 behaves as single
        run(2, 10, 200, 7, 2, 9, 1);     // reset mid-sweep
        run(1, 250, 255, 3, 1, 12, 0);   // sawtooth with carry

        for (int i = 0; i < 40; i++) begin
            m  = $urandom_range(0, 3);
            fs = $urandom_range(0, 255);
            fe = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(fs, 255);
            st = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(4, 120);
            dw = $urandom_range(0, 4);
            rs = ($urandom_range(0, 7) == 0);
            if (m == 1 || m == 2 || rs || $urandom_range(0, 2) == 0) sa = $urandom_range(1, 80);
            else sa = 0;
            run(m, fs, fe, st, dw, sa, rs);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Frequency-sweep sequencer for the DDS channel frequency word. On a start command it latches a sweep configuration and drives a frequency word through a start→stop ramp, holding each value for a programmable dwell. It emits a one-cycle update strobe on every word change so the downstream DDS phase accumulator is re-synchronised. It sits between the keypad/parameter register stage and the DDS core, in place of a static frequency word, when sweep mode is selected.

## Interface
- FW_W, 8: frequency word width.
- DWELL_W, 16: dwell counter width.
- FW_RST, 1: `fword` value after reset.
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle sweep start command; honoured only in IDLE.
- stop_req  in  1  one-cycle abort; honoured in any state.
- mode  in  2  00 single up-sweep, 01 repeat (sawtooth), 10 triangle, 11 treated as 00.
- f_start  in  FW_W  first/lowest word.
- f_stop  in  FW_W  highest word allowed.
- f_step  in  FW_W  increment per step.
- dwell  in  DWELL_W  cycles each word is held; 0 is treated as 1.
- fword  out  FW_W  current frequency word, registered.
- upd  out  1  one-cycle strobe, high in the same cycle `fword` takes a new value.
- busy  out  1  high while a sweep runs.
- done  out  1  one-cycle pulse when a single sweep completes.
- cfg_err  out  1  one-cycle pulse when a start is rejected.

## Operation
- States: IDLE, UP, DN. A direction register is implied by the state.
- Reset values: `fword`=FW_RST, `upd`=0, `busy`=0, `done`=0, `cfg_err`=0, state IDLE, dwell counter 0.
- IDLE + start:
  - If f_step==0 or f_start>f_stop: pulse `cfg_err` and stay in IDLE. `fword` is unchanged.
  - Otherwise: latch mode, f_start, f_stop, f_step and D=max(dwell,1), then load `fword`=f_start, pulse `upd`, set `busy`, and go to UP.
  - Config input changes after the latch are ignored until the next start.
- Dwell: the counter loads D on every word load and decrements each cycle. The step is taken in the cycle the counter reaches 1. Each word is therefore visible for exactly D cycles.
- UP step: sum = fword + f_step, computed at FW_W+1 bits.
  - If sum ≤ f_stop with no carry: `fword` = sum.
  - Otherwise (top reached):
    - mode 00: `done` pulse, `busy`=0, go to IDLE, `fword` holds its last value.
    - mode 01: `fword` = f_start, stay in UP.
    - mode 10: go to DN, `fword` = max(fword − f_step, f_start), computed with borrow detection (a borrow yields f_start).
- DN step: diff = fword − f_step.
  - If there is no borrow and diff ≥ f_start: `fword` = diff.
  - Otherwise: go to UP, `fword` = min(fword + f_step, f_stop), computed with carry detection (a carry yields f_stop).
- `upd` fires on every load from IDLE. On steps it fires only if the new value differs from the current `fword`. Example: with f_start==f_stop in mode 01 or 10, the word holds with no `upd` until stop_req.
- stop_req: go to IDLE on the next edge, `busy`=0, `fword` held, no `done`, no `upd`. stop_req has priority over start and over a same-cycle step.
- A start while busy is ignored.
- A reset mid-sweep returns everything to the reset values immediately.

## Timing
- start sampled at edge N (IDLE, valid config): at edge N+1, `fword`=f_start, `upd`=1, `busy`=1.
- Word k is loaded at edge N+1+k·D. `upd` is high for the cycle following each load edge only.
- Single sweep with M words: `done`=1 and `busy`=0 from edge N+1+M·D, for one cycle.
- `cfg_err` is asserted at edge N+1 for one cycle.
- stop_req at edge S: `busy`=0 from edge S+1.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Reset: assert reset mid-sweep → `fword`=1, `busy`=0, all strobes 0 immediately, and held while reset is high.
- Single sweep: f_start=10, f_stop=40, f_step=10, dwell=3, mode 00 → `fword` steps 10,20,30,40 with 3 cycles each, 4 `upd` pulses, `done` 12 cycles after the first load, `fword` stays 40.
- Non-multiple stop and overflow: f_start=10, f_stop=35, f_step=10 → words 10,20,30 then `done`. With FW_W=8, f_start=200, f_stop=255, f_step=100 → word 200 only, then `done` (the carry is detected).
- Triangle: f_start=10, f_stop=30, f_step=10, dwell=1, mode 10 → 10,20,30,20,10,20,… with `upd` every cycle. stop_req mid-sweep → `busy` drops the next cycle, word holds, no `done`.
- Repeat with equal bounds: f_start=f_stop=50, mode 01 → one `upd` at load, then no further `upd`, `busy` stays high until stop_req.
- Config errors and collisions: f_step=0 → `cfg_err` pulse, stays IDLE. f_start=40, f_stop=10 → `cfg_err`. start and stop_req in the same cycle → no sweep starts. dwell=0 → each word is held for 1 cycle.
